// File: rtl/reg_write_arbiter_if.sv
// Bundle of the writeback, host-loader and register-file write-port signals
// that surround the $s register-file write arbiter.
interface reg_write_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              wb_valid;
  logic [4:0]        wb_reg;
  logic [DATA_W-1:0] wb_data;
  logic              ld_valid;
  logic              ld_ready;
  logic [4:0]        ld_reg;
  logic [DATA_W-1:0] ld_data;
  logic              reg_write;
  logic [4:0]        write_reg;
  logic [DATA_W-1:0] write_data;
  logic              stall_req;
  logic [1:0]        fifo_count;
  logic              addr_err;
  logic              ovr_err;

  modport master (
    output wb_valid, wb_reg, wb_data, ld_valid, ld_reg, ld_data,
    input  ld_ready, reg_write, write_reg, write_data, stall_req,
           fifo_count, addr_err, ovr_err
  );

  modport slave (
    input  wb_valid, wb_reg, wb_data, ld_valid, ld_reg, ld_data,
    output ld_ready, reg_write, write_reg, write_data, stall_req,
           fifo_count, addr_err, ovr_err
  );
endinterface

// File: rtl/reg_write_arbiter.sv
// Shares the $s register-file write port between pipeline writeback (fixed
// priority) and a host loader queued in a 2-entry FIFO, with a starvation guard.
module reg_write_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int DATA_W       = 32
) (
  input logic               clock,
  input logic               reset_n,
  reg_write_arbiter_if.slave bus
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_limit_check
    $error("reg_write_arbiter: STARVE_LIMIT must be in 1..15");
  end

  localparam logic [3:0] LIMIT_M1 = 4'(STARVE_LIMIT - 1);

  logic [4:0]        fifo_reg  [2];
  logic [DATA_W-1:0] fifo_data [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic [3:0]        starve_cnt;

  logic              ready;
  logic              push_fire;
  logic              addr_ok;
  logic              push;
  logic              pop;
  logic              lost;
  logic              starve_hit;

  logic              wr_en_p1;
  logic [4:0]        wr_reg_p1;
  logic [DATA_W-1:0] wr_data_p1;
  logic              stall_p1;
  logic              addr_err_q;
  logic              ovr_err_q;

  // Arbitration and handshake decode for the current cycle
  always_comb begin
    ready      = (count != 2'd2);
    push_fire  = bus.ld_valid & ready;
    addr_ok    = (bus.ld_reg[4:3] == 2'b10);
    push       = push_fire & addr_ok;
    pop        = ~bus.wb_valid & (count != 2'd0);
    lost       = bus.wb_valid & (count != 2'd0);
    starve_hit = lost & (starve_cnt == LIMIT_M1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // FIFO payload needs no reset: only slots covered by count are ever read
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_reg[wr_ptr]  <= bus.ld_reg;
      fifo_data[wr_ptr] <= bus.ld_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= 4'd0;
      stall_p1   <= 1'b0;
    end else begin
      stall_p1 <= starve_hit;
      if (pop || count == 2'd0 || starve_hit) begin
        starve_cnt <= 4'd0;
      end else if (lost) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

  // Stage p1: registered register-file write port
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_en_p1   <= 1'b0;
      wr_reg_p1  <= 5'd0;
      wr_data_p1 <= '0;
    end else if (bus.wb_valid) begin
      wr_en_p1   <= 1'b1;
      wr_reg_p1  <= bus.wb_reg;
      wr_data_p1 <= bus.wb_data;
    end else if (pop) begin
      wr_en_p1   <= 1'b1;
      wr_reg_p1  <= fifo_reg[rd_ptr];
      wr_data_p1 <= fifo_data[rd_ptr];
    end else begin
      wr_en_p1   <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_err_q <= 1'b0;
      ovr_err_q  <= 1'b0;
    end else begin
      if (push_fire && !addr_ok)      addr_err_q <= 1'b1;
      if (bus.wb_valid && stall_p1)   ovr_err_q  <= 1'b1;
    end
  end

  assign bus.ld_ready   = ready;
  assign bus.fifo_count = count;
  assign bus.reg_write  = wr_en_p1;
  assign bus.write_reg  = wr_reg_p1;
  assign bus.write_data = wr_data_p1;
  assign bus.stall_req  = stall_p1;
  assign bus.addr_err   = addr_err_q;
  assign bus.ovr_err    = ovr_err_q;

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Shares the single write port of the 8-entry $s register file (regs 16..23) between two sources: pipeline writeback and a host loader that preloads matrix operands.
- Writeback has fixed priority. Host writes queue in a 2-entry FIFO and fill idle write slots.
- A starvation guard asks the pipeline to freeze writeback for one cycle so queued host writes always drain.
- Sits between the WB stage/host loader and the register file's reg_write/write_reg/write_data inputs.

Parameters:
- STARVE_LIMIT, 4: consecutive lost host arbitrations before stall_req fires. Legal range 1..15.
- DATA_W, 32: write data width.

Ports:
- clock  in  1  system clock; all state on posedge
- reset_n  in  1  asynchronous active-low reset
- wb_valid  in  1  writeback write request this cycle; never back-pressured
- wb_reg  in  5  writeback destination register number
- wb_data  in  DATA_W  writeback data
- ld_valid  in  1  host write request
- ld_ready  out  1  host request accepted when ld_valid & ld_ready at posedge
- ld_reg  in  5  host destination register number
- ld_data  in  DATA_W  host data
- reg_write  out  1  register-file write enable (registered)
- write_reg  out  5  register-file write address (registered)
- write_data  out  DATA_W  register-file write data (registered)
- stall_req  out  1  request to pipeline: hold writeback next cycle (registered)
- fifo_count  out  2  host FIFO occupancy 0..2
- addr_err  out  1  sticky: host sent register outside 16..23
- ovr_err  out  1  sticky: wb_valid=1 during a cycle with stall_req=1

Behaviour:
- Reset (reset_n=0, asynchronous): reg_write, write_reg, write_data, stall_req, addr_err, ovr_err = 0; FIFO empty; starve counter 0. Handshakes are ignored while reset is asserted.
- ld_ready = (fifo_count != 2), combinational from state. Pushes and pops in the same cycle are both permitted.
- Push, when ld_valid & ld_ready at the edge:
  - If ld_reg is in 16..23, {ld_reg, ld_data} enters the FIFO tail.
  - Otherwise the request is consumed (handshake completes), not stored, and addr_err is set to 1 until reset.
- Arbitration is evaluated each cycle on current inputs and FIFO state:
  - wb_valid=1: writeback granted. Next edge: reg_write=1, write_reg=wb_reg, write_data=wb_data. wb_reg is passed through unchecked.
  - wb_valid=0 and fifo_count>0: FIFO head popped. Next edge: reg_write=1 with head reg/data.
  - Otherwise: next edge reg_write=0. write_reg/write_data hold their last value.
- Latency:
  - Writeback: 1 cycle, input cycle N drives the register-file write in cycle N+1.
  - Host: a push at edge N is poppable from cycle N+1, so the earliest write is in cycle N+2. No same-cycle bypass.
- Outputs change on posedge only, so they are stable through the clock-low phase in which the register file writes.
- Starvation guard:
  - The starve counter increments on each cycle where fifo_count>0 and wb_valid=1 (host lost).
  - It clears on any host pop, and whenever the FIFO is empty.
  - If the host loses when the counter equals STARVE_LIMIT-1, stall_req=1 at the next edge for exactly one cycle, and the counter clears.
- Stall-cycle contract: the pipeline drives wb_valid=0 during the cycle with stall_req=1, so the FIFO head is granted.
  - If wb_valid=1 anyway, writeback still wins and ovr_err is set sticky.
  - The counter then resumes counting from 0.
- FIFO full (count 2) with a simultaneous pop: ld_ready=0 that cycle. A push is not accepted even though a slot frees; it is accepted next cycle.
- Ordering: host writes retire in acceptance order. Writeback and host writes to the same register retire in grant order (last granted wins).
- Reset mid-operation: queued host entries are discarded. A write in flight on the outputs is cleared (reg_write=0) immediately.

Test Plan:
- Reset, then wb_valid=1, wb_reg=17, wb_data=0x0000_00AB in cycle 1 -> cycle 2: reg_write=1, write_reg=17, write_data=0xAB. Cycle 3 with wb_valid=0: reg_write=0.
- Idle pipeline; host pushes (18,0x11) then (19,0x22) on consecutive edges -> writes to 18 then 19 appear 2 cycles after each push. fifo_count peaks at 1. ld_ready stays 1.
- wb_valid held 1 with wb_reg=20; host pushes (21,0x55); STARVE_LIMIT=4 -> stall_req=1 for one cycle after 4 lost cycles. With wb_valid=0 in that cycle, write (21,0x55) follows. ovr_err stays 0.
- Same as above but wb_valid kept 1 during the stall cycle -> ovr_err=1 (sticky); writeback still written; next stall_req after another 4 lost cycles.
- Host pushes ld_reg=5, then ld_reg=31 -> both handshakes complete, no register-file write, fifo_count stays 0, addr_err=1 until reset.
- FIFO filled (count 2) under continuous wb_valid; reset_n pulled low mid-sequence -> all outputs 0 asynchronously, fifo_count=0, no host write after reset release.
